// File: rtl/dqs_eye_centering_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dqs_eye_centering_ctrl
// Purpose  : Read-DQS delay-line training sequencer for one DDR3 byte lane.
//            Sweeps the IOD RX delay tap upward from 0 and samples the
//            eye-monitor flags after each move to find the passing window.
//            It then walks the delay line back down and parks it at the
//            window centre.
// Ports    : FAB_CLK, RESET_N (sync, active-low), START (1-cycle request)
//            EYE_MONITOR_EARLY/LATE, DELAY_LINE_OUT_OF_RANGE  - IOD status
//            DELAY_LINE_LOAD/MOVE/DIRECTION, EYE_MONITOR_CLEAR_FLAGS - IOD ctl
//            BUSY, DONE, ERROR, LEFT_EDGE, RIGHT_EDGE, CENTER_TAP - status
// Revision : 1.0  initial release
// ============================================================================
module dqs_eye_centering_ctrl #(
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 255,
  parameter int SETTLE_CYCLES = 8,
  parameter int MIN_WINDOW    = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [TAP_W-1:0] LEFT_EDGE,
  output logic [TAP_W-1:0] RIGHT_EDGE,
  output logic [TAP_W-1:0] CENTER_TAP
);

  localparam int                 CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0]   TAP_LIMIT   = TAP_W'(MAX_TAPS);
  localparam logic [TAP_W:0]     MIN_WIN     = (TAP_W+1)'(MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_CLEAR  = 4'd2,
    S_SETTLE = 4'd3,
    S_SAMPLE = 4'd4,
    S_STEP   = 4'd5,
    S_CENTER = 4'd6,
    S_FIN    = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             find_right_q, find_right_d;
  logic             load_q, load_d, move_q, move_d, dir_q, dir_d, clear_q, clear_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [TAP_W-1:0] left_q, left_d, right_q, right_d, center_q, center_d;

  // SAMPLE-state decision helpers
  logic             pass_w, limit_w, eval_w, go_step_w, go_err_w;
  logic [TAP_W-1:0] eval_left_w, eval_right_w, mid_w;
  logic [TAP_W:0]   sum_w, window_w;

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      settle_cnt_q <= '0;
      find_right_q <= 1'b0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      center_q     <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      settle_cnt_q <= settle_cnt_d;
      find_right_q <= find_right_d;
      load_q       <= load_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      clear_q      <= clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      left_q       <= left_d;
      right_q      <= right_d;
      center_q     <= center_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    settle_cnt_d = settle_cnt_q;
    find_right_d = find_right_q;
    load_d       = 1'b0;
    move_d       = 1'b0;
    clear_d      = 1'b0;
    dir_d        = dir_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    left_d       = left_q;
    right_d      = right_q;
    center_d     = center_q;

    pass_w       = !EYE_MONITOR_EARLY && !EYE_MONITOR_LATE;
    limit_w      = (tap_q == TAP_LIMIT) || DELAY_LINE_OUT_OF_RANGE;
    eval_w       = 1'b0;
    go_step_w    = 1'b0;
    go_err_w     = 1'b0;
    eval_right_w = tap_q;
    // A window opened at this very sample has its left edge at the current tap.
    eval_left_w  = find_right_q ? left_q : tap_q;
    sum_w        = '0;
    window_w     = '0;
    mid_w        = '0;

    // Outputs are registered, so each pulse is raised on the edge entering its state.
    case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (START) begin
          state_d      = S_LOAD;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          left_d       = '0;
          right_d      = '0;
          center_d     = '0;
          find_right_d = 1'b0;
          load_d       = 1'b1;
          dir_d        = 1'b1;
          tap_d        = '0;
        end
      end
      S_LOAD: begin
        state_d = S_CLEAR;
        clear_d = 1'b1;
      end
      S_CLEAR: begin
        state_d      = S_SETTLE;
        settle_cnt_d = '0;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (!find_right_q) begin
          if (pass_w) begin
            left_d       = tap_q;
            find_right_d = 1'b1;
          end
          if (!limit_w)    go_step_w = 1'b1;
          else if (pass_w) eval_w    = 1'b1;   // window opens on the last tap
          else             go_err_w  = 1'b1;
        end else begin
          if (!pass_w) begin
            eval_w       = 1'b1;
            eval_right_w = tap_q - 1'b1;
          end else if (limit_w) begin
            eval_w       = 1'b1;
          end else begin
            go_step_w    = 1'b1;
          end
        end

        if (eval_w) begin
          right_d  = eval_right_w;
          sum_w    = {1'b0, eval_left_w} + {1'b0, eval_right_w};
          window_w = {1'b0, eval_right_w} - {1'b0, eval_left_w} + 1'b1;
          mid_w    = TAP_W'(sum_w >> 1);
          if (window_w < MIN_WIN) begin
            go_err_w = 1'b1;
          end else begin
            center_d = mid_w;
            dir_d    = 1'b0;          // MOVE is low here, so flipping is safe
            if (tap_q == mid_w) begin
              state_d = S_FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_CENTER;
            end
          end
        end

        if (go_step_w) begin
          state_d = S_STEP;
          move_d  = 1'b1;
          tap_d   = tap_q + 1'b1;
        end

        if (go_err_w) begin
          state_d  = S_ERR;
          busy_d   = 1'b0;
          error_d  = 1'b1;
          center_d = '0;
          load_d   = 1'b1;            // return the delay line to tap 0
          tap_d    = '0;
        end
      end
      S_STEP: begin
        state_d = S_CLEAR;
        clear_d = 1'b1;
      end
      S_CENTER: begin
        // Every MOVE cycle is followed by an idle cycle; the park check only
        // happens in idle cycles so the last pulse is always complete.
        if (!move_q) begin
          if (tap_q == center_q) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            move_d = 1'b1;
            tap_d  = tap_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign ERROR                   = error_q;
  assign LEFT_EDGE               = left_q;
  assign RIGHT_EDGE              = right_q;
  assign CENTER_TAP              = center_q;

endmodule
`default_nettype wire

// File: tb/tb_dqs_eye_centering_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dqs_eye_centering_ctrl
// Purpose  : Self-checking bench. An eye model tracks the physical delay-line
//            position from the LOAD/MOVE pulses and drives the flags. A
//            trace model expands each training run into the per-cycle
//            output sequence, which one compare process checks every cycle.
//            Hand-computed edge/centre/park values pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dqs_eye_centering_ctrl;

  localparam int TAP_W = 8;
  localparam int MAXT  = 255;
  localparam int SETL  = 8;
  localparam int MINW  = 4;

  logic clk = 1'b0;
  logic rst_n, start, early, late, oor;
  logic ld, mv, dir, clr, busy, done, err;
  logic [TAP_W-1:0] left_e, right_e, center_t;

  dqs_eye_centering_ctrl #(
    .TAP_W(TAP_W), .MAX_TAPS(MAXT), .SETTLE_CYCLES(SETL), .MIN_WINDOW(MINW)
  ) dut (
    .FAB_CLK(clk), .RESET_N(rst_n), .START(start),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .DELAY_LINE_LOAD(ld), .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dir),
    .EYE_MONITOR_CLEAR_FLAGS(clr), .BUSY(busy), .DONE(done), .ERROR(err),
    .LEFT_EDGE(left_e), .RIGHT_EDGE(right_e), .CENTER_TAP(center_t)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- eye / delay-line model ----------------
  bit eye_on = 1'b0;
  int eye_lo = 0, eye_hi = 0, oor_tap = 1000;
  int pos = 0, inc_cnt = 0, dec_cnt = 0, load_cnt = 0;

  always @(negedge clk) begin
    if (ld === 1'b1) begin
      pos = 0;
      load_cnt++;
    end else if (mv === 1'b1) begin
      if (dir) begin pos++; inc_cnt++; end
      else     begin pos--; dec_cnt++; end
    end
    early = !(eye_on && pos >= eye_lo && pos <= eye_hi) && (pos < eye_lo || !eye_on);
    late  = !(eye_on && pos >= eye_lo && pos <= eye_hi) && eye_on && (pos > eye_hi);
    oor   = (pos >= oor_tap);
  end

  // ---------------- expected trace model ----------------
  // vector = {load, move, dir, clear, busy, done, error, left, right, center}
  logic [30:0] exp_q[$];
  logic [30:0] final_vec;

  function automatic logic [30:0] vec(bit l_, bit m_, bit d_, bit c_, bit b_, bit dn_, bit e_,
                                      int lft, int rgt, int ctr);
    return {l_, m_, d_, c_, b_, dn_, e_, 8'(lft), 8'(rgt), 8'(ctr)};
  endfunction

  task automatic build();
    int tap = 0, lft = 0, rgt = 0, ctr = 0, k;
    bit right_ph = 0, is_err = 0, finished = 0, p, lim;
    exp_q.delete();
    exp_q.push_back(vec(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    while (!finished) begin
      exp_q.push_back(vec(0, 0, 1, 1, 1, 0, 0, lft, rgt, 0));          // clear
      for (int s = 0; s < SETL; s++)
        exp_q.push_back(vec(0, 0, 1, 0, 1, 0, 0, lft, rgt, 0));        // settle
      exp_q.push_back(vec(0, 0, 1, 0, 1, 0, 0, lft, rgt, 0));          // sample
      p   = eye_on && tap >= eye_lo && tap <= eye_hi;
      lim = (tap == MAXT) || (tap >= oor_tap);
      if (!right_ph) begin
        if (p) begin lft = tap; right_ph = 1; end
      end else if (!p) begin
        rgt = tap - 1; finished = 1;
      end
      if (!finished && lim) begin
        finished = 1;
        if (right_ph) rgt = tap;
        else          is_err = 1;
      end
      if (!finished) begin
        exp_q.push_back(vec(0, 1, 1, 0, 1, 0, 0, lft, rgt, 0));        // step
        tap++;
      end
    end
    if (!is_err && (rgt - lft + 1) < MINW) is_err = 1;
    if (is_err) begin
      exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 1, lft, rgt, 0));
      final_vec = vec(0, 0, 1, 0, 0, 0, 1, lft, rgt, 0);
    end else begin
      ctr = (lft + rgt) / 2;
      k   = tap - ctr;
      for (int i = 0; i < k; i++) begin
        exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 0, lft, rgt, ctr));
        exp_q.push_back(vec(0, 1, 0, 0, 1, 0, 0, lft, rgt, ctr));
      end
      if (k > 0) exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 0, lft, rgt, ctr));
      final_vec = vec(0, 0, 0, 0, 0, 1, 0, lft, rgt, ctr);
    end
    exp_q.push_back(final_vec);
  endtask

  // ---------------- single compare process ----------------
  bit          checking = 1'b0;
  int          idx = 0;
  logic [30:0] cmp_exp, cmp_act;

  always @(negedge clk) begin
    if (checking) begin
      cmp_exp = (idx < exp_q.size()) ? exp_q[idx] : final_vec;
      cmp_act = {ld, mv, dir, clr, busy, done, err, left_e, right_e, center_t};
      n_cmp++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL trace[%0d] got=%h want=%h (ld mv dir clr busy done err | L R C)",
                 idx, cmp_act, cmp_exp);
      end
      idx++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic setup(input bit on, input int lo, input int hi, input int oo);
    eye_on = on; eye_lo = lo; eye_hi = hi; oor_tap = oo;
    build();
    inc_cnt = 0; dec_cnt = 0; load_cnt = 0;
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    checking = 1'b1;
  endtask

  task automatic run(input bit on, input int lo, input int hi, input int oo);
    setup(on, lo, hi, oo);
    kick();
    repeat (exp_q.size() + 4) @(negedge clk);
    checking = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int l, input int r, input int c,
                            input int dn, input int er);
    chk({tag, "_left"},   int'(left_e),   l);
    chk({tag, "_right"},  int'(right_e),  r);
    chk({tag, "_center"}, int'(center_t), c);
    chk({tag, "_done"},   int'(done),     dn);
    chk({tag, "_error"},  int'(err),      er);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, int'({ld, mv, dir, clr, busy, done, err, left_e, right_e, center_t}), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;                       // START during reset must lose
    @(posedge clk); #1 start = 1'b0;
    chk_all_zero("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk_all_zero("idle_after_reset");

    // 1: window 20..39 -> centre 29, delay line parked at 29
    run(1, 20, 39, 1000);
    chk_result("s1", 20, 39, 29, 1, 0);
    chk("s1_park_pos", pos, 29);
    chk("s1_inc_moves", inc_cnt, 40);

    // 2: no eye at all -> full sweep, error, delay line reloaded
    run(0, 0, 0, 1000);
    chk_result("s2", 0, 0, 0, 0, 1);
    chk("s2_inc_moves", inc_cnt, 255);
    chk("s2_dec_moves", dec_cnt, 0);
    chk("s2_load_pulses", load_cnt, 2);
    chk("s2_pos", pos, 0);

    // 3: window too narrow (3 taps)
    run(1, 100, 102, 1000);
    chk_result("s3", 100, 102, 0, 0, 1);

    // 4: window runs into the top tap
    run(1, 240, 255, 1000);
    chk_result("s4", 240, 255, 247, 1, 0);
    chk("s4_park_pos", pos, 247);

    // 5: out-of-range at tap 50 closes a window that opened at 45
    run(1, 45, 200, 50);
    chk_result("s5", 45, 50, 47, 1, 0);
    chk("s5_park_pos", pos, 47);
    chk("s5_dec_moves", dec_cnt, 3);

    // 6: START while busy is ignored, reset mid-sweep aborts, restart is clean
    setup(1, 20, 39, 1000);
    kick();
    for (int i = 0; i < 3000 && pos < 10; i++) @(negedge clk);
    chk("s6_reach_tap10", int'(pos >= 10), 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3000 && pos < 30; i++) @(negedge clk);
    chk("s6_reach_tap30", int'(pos >= 30), 1);
    chk("s6_busy_before_reset", int'(busy), 1);
    @(posedge clk); #1 checking = 1'b0; rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk_all_zero("s6_after_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk_all_zero("s6_idle");
    run(1, 20, 39, 1000);
    chk_result("s6", 20, 39, 29, 1, 0);
    chk("s6_park_pos", pos, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
